// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one external memory port between the data cache
// (c_*) and the DMA engine (d_*). Grants are round-robin and burst-locked.
// A grant is held until the owner's last beat is accepted and all of its read
// responses have returned. Read data is routed back to the owner. A read
// response arriving with nothing outstanding sets a sticky error.
//
// Ports:
//   clk_i, rst_ni                    clock, async active-low reset
//   c_req_i/we/addr/wdata/last_i     cache beat request
//   c_gnt_o, c_ready_o               cache owns port, cache beat accepted
//   c_rvalid_o, c_rdata_o            read response to cache
//   d_*                              DMA equivalents of the c_* ports
//   m_valid_o/we/addr/wdata_o        beat to memory
//   m_ready_i                        memory accepts beat
//   m_rvalid_i, m_rdata_i            in-order read response from memory
//   owner_o                          00 none, 01 cache, 10 dma
//   err_o                            sticky protocol error
module mem_port_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned MAX_OUT = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          c_req_i,
  input  logic          c_we_i,
  input  logic [AW-1:0] c_addr_i,
  input  logic [DW-1:0] c_wdata_i,
  input  logic          c_last_i,
  output logic          c_gnt_o,
  output logic          c_ready_o,
  output logic          c_rvalid_o,
  output logic [DW-1:0] c_rdata_o,
  input  logic          d_req_i,
  input  logic          d_we_i,
  input  logic [AW-1:0] d_addr_i,
  input  logic [DW-1:0] d_wdata_i,
  input  logic          d_last_i,
  output logic          d_gnt_o,
  output logic          d_ready_o,
  output logic          d_rvalid_o,
  output logic [DW-1:0] d_rdata_o,
  output logic          m_valid_o,
  output logic          m_we_o,
  output logic [AW-1:0] m_addr_o,
  output logic [DW-1:0] m_wdata_o,
  input  logic          m_ready_i,
  input  logic          m_rvalid_i,
  input  logic [DW-1:0] m_rdata_i,
  output logic [1:0]    owner_o,
  output logic          err_o
);

  localparam int unsigned CW = $clog2(MAX_OUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CACHE,
    S_DMA,
    S_DRAIN_C,
    S_DRAIN_D
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] out_q, out_d;
  logic          rr_dma_last_q, rr_dma_last_d;  // 1: DMA was granted last
  logic          err_q, err_d;

  logic own_c, own_d;
  logic room, accept, own_last, rsp_ok;

  // State, outstanding count, round-robin pointer and sticky error
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      out_q         <= '0;
      rr_dma_last_q <= 1'b1;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      out_q         <= out_d;
      rr_dma_last_q <= rr_dma_last_d;
      err_q         <= err_d;
    end
  end

  // Issue mux, outstanding accounting and next-state logic
  always_comb begin
    state_d       = state_q;
    rr_dma_last_d = rr_dma_last_q;
    err_d         = err_q;
    m_valid_o     = 1'b0;
    m_we_o        = 1'b0;
    m_addr_o      = '0;
    m_wdata_o     = '0;
    own_last      = 1'b0;

    own_c = (state_q == S_CACHE) || (state_q == S_DRAIN_C);
    own_d = (state_q == S_DMA)   || (state_q == S_DRAIN_D);
    room  = out_q < CW'(MAX_OUT);

    // A last beat stalled at the outstanding limit is an ordinary stall
    if (state_q == S_CACHE) begin
      m_valid_o = c_req_i & room;
      m_we_o    = c_we_i;
      m_addr_o  = c_addr_i;
      m_wdata_o = c_wdata_i;
      own_last  = c_last_i;
    end else if (state_q == S_DMA) begin
      m_valid_o = d_req_i & room;
      m_we_o    = d_we_i;
      m_addr_o  = d_addr_i;
      m_wdata_o = d_wdata_i;
      own_last  = d_last_i;
    end

    accept = m_valid_o & m_ready_i;
    // A response with nothing outstanding is dropped and flagged
    rsp_ok = m_rvalid_i & (out_q != '0);
    out_d  = out_q + CW'(accept & ~m_we_o) - CW'(rsp_ok);
    if (m_rvalid_i && (out_q == '0)) begin
      err_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (c_req_i && (!d_req_i || rr_dma_last_q)) begin
          state_d       = S_CACHE;
          rr_dma_last_d = 1'b0;
        end else if (d_req_i) begin
          state_d       = S_DMA;
          rr_dma_last_d = 1'b1;
        end
      end
      S_CACHE: begin
        if (accept && own_last) begin
          state_d = (out_d == '0) ? S_IDLE : S_DRAIN_C;
        end
      end
      S_DMA: begin
        if (accept && own_last) begin
          state_d = (out_d == '0) ? S_IDLE : S_DRAIN_D;
        end
      end
      S_DRAIN_C, S_DRAIN_D: begin
        if (out_d == '0) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Requester-side routing
  assign c_gnt_o    = own_c;
  assign d_gnt_o    = own_d;
  assign c_ready_o  = accept & (state_q == S_CACHE);
  assign d_ready_o  = accept & (state_q == S_DMA);
  assign c_rvalid_o = rsp_ok & own_c;
  assign d_rvalid_o = rsp_ok & own_d;
  assign c_rdata_o  = own_c ? m_rdata_i : '0;
  assign d_rdata_o  = own_d ? m_rdata_i : '0;
  assign owner_o    = {own_d, own_c};
  assign err_o      = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed stimulus pushes expected
// memory beats and read responses into queues; a negedge monitor pops and
// compares them whenever the DUT presents a beat or a response.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        c_req, c_we, c_last;
  logic [31:0] c_addr, c_wdata;
  logic        c_gnt_o, c_ready_o, c_rvalid_o;
  logic [31:0] c_rdata_o;
  logic        d_req, d_we, d_last;
  logic [31:0] d_addr, d_wdata;
  logic        d_gnt_o, d_ready_o, d_rvalid_o;
  logic [31:0] d_rdata_o;
  logic        m_valid_o, m_we_o;
  logic [31:0] m_addr_o, m_wdata_o;
  logic        m_ready, m_rvalid;
  logic [31:0] m_rdata;
  logic [1:0]  owner_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0]  own;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } beat_t;

  typedef struct packed {
    logic [1:0]  port;
    logic [31:0] data;
  } rsp_t;

  beat_t exp_beats[$];
  rsp_t  exp_rsps[$];
  beat_t mon_beat;
  rsp_t  mon_rsp;

  mem_port_arbiter dut (
    .clk_i(clk), .rst_ni(rst_n),
    .c_req_i(c_req), .c_we_i(c_we), .c_addr_i(c_addr), .c_wdata_i(c_wdata),
    .c_last_i(c_last), .c_gnt_o(c_gnt_o), .c_ready_o(c_ready_o),
    .c_rvalid_o(c_rvalid_o), .c_rdata_o(c_rdata_o),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_last_i(d_last), .d_gnt_o(d_gnt_o), .d_ready_o(d_ready_o),
    .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
    .m_valid_o(m_valid_o), .m_we_o(m_we_o), .m_addr_o(m_addr_o),
    .m_wdata_o(m_wdata_o), .m_ready_i(m_ready), .m_rvalid_i(m_rvalid),
    .m_rdata_i(m_rdata), .owner_o(owner_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    c_req = 0; c_we = 0; c_last = 0; c_addr = '0; c_wdata = '0;
    d_req = 0; d_we = 0; d_last = 0; d_addr = '0; d_wdata = '0;
    m_ready = 0; m_rvalid = 0; m_rdata = '0;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    idle_inputs();
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic push_beat(input logic [1:0] own, input logic we,
                           input logic [31:0] addr, input logic [31:0] wdata);
    beat_t b;
    b.own = own; b.we = we; b.addr = addr; b.wdata = wdata;
    exp_beats.push_back(b);
  endtask

  task automatic push_rsp(input logic [1:0] port, input logic [31:0] data);
    rsp_t r;
    r.port = port; r.data = data;
    exp_rsps.push_back(r);
  endtask

  // Scoreboard monitor: compares every accepted beat and forwarded response
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_valid_o && m_ready) begin
        checks++;
        if (exp_beats.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected: got addr %0h expected no beat", m_addr_o);
        end else begin
          mon_beat = exp_beats.pop_front();
          if ({owner_o, m_we_o, m_addr_o, m_wdata_o} !== mon_beat) begin
            errors++;
            $display("FAIL beat: got own %0h we %0b addr %0h wdata %0h expected own %0h we %0b addr %0h wdata %0h",
                     owner_o, m_we_o, m_addr_o, m_wdata_o,
                     mon_beat.own, mon_beat.we, mon_beat.addr, mon_beat.wdata);
          end
        end
      end
      if (c_rvalid_o || d_rvalid_o) begin
        checks++;
        if (exp_rsps.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected: got port %0b%0b expected no response", d_rvalid_o, c_rvalid_o);
        end else begin
          mon_rsp = exp_rsps.pop_front();
          if ({d_rvalid_o, c_rvalid_o, (d_rvalid_o ? d_rdata_o : c_rdata_o)} !== mon_rsp) begin
            errors++;
            $display("FAIL rsp: got port %0b%0b data %0h expected port %0b data %0h",
                     d_rvalid_o, c_rvalid_o, (d_rvalid_o ? d_rdata_o : c_rdata_o),
                     mon_rsp.port, mon_rsp.data);
          end
        end
      end
    end
  end

  initial begin
    logic [1:0]  tie_own[8];
    logic [31:0] bp_addr[7];
    logic        acc;
    int          b;
    int          dr_cnt;
    int          cr_cnt;

    // ---------------- reset state ----------------
    rst_n = 1'b0;
    idle_inputs();
    #2;
    chk("rst_owner", 64'(owner_o), 64'h0);
    chk("rst_m_valid", 64'(m_valid_o), 64'h0);
    chk("rst_err", 64'(err_o), 64'h0);
    chk("rst_gnt", 64'({c_gnt_o, d_gnt_o}), 64'h0);
    reset_dut();

    // ---------------- single 4-beat cache write ----------------
    for (int i = 0; i < 4; i++) push_beat(2'b01, 1'b1, 32'h1000 + 32'(4 * i), 32'hA0 + 32'(i));
    c_req = 1; c_we = 1; c_last = 0; c_addr = 32'h1000; c_wdata = 32'hA0; m_ready = 1;
    #1;
    chk("t1_idle_no_valid", 64'(m_valid_o), 64'h0);
    chk("t1_idle_no_gnt", 64'(c_gnt_o), 64'h0);
    step();
    #1;
    chk("t1_gnt", 64'(c_gnt_o), 64'h1);
    for (int i = 0; i < 4; i++) begin
      c_addr = 32'h1000 + 32'(4 * i);
      c_wdata = 32'hA0 + 32'(i);
      c_last = (i == 3);
      #1;
      chk("t1_owner", 64'(owner_o), 64'h1);
      chk("t1_ready", 64'(c_ready_o), 64'h1);
      step();
    end
    c_req = 0; c_last = 0;
    #1;
    chk("t1_owner_after", 64'(owner_o), 64'h0);
    chk("t1_gnt_after", 64'(c_gnt_o), 64'h0);

    // ---------------- tie out of reset ----------------
    reset_dut();
    tie_own = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
    for (int i = 0; i < 2; i++) begin
      push_beat(2'b01, 1'b1, 32'h100, 32'h11);
      push_beat(2'b10, 1'b1, 32'h200, 32'h22);
    end
    c_we = 1; c_last = 1; c_addr = 32'h100; c_wdata = 32'h11;
    d_we = 1; d_last = 1; d_addr = 32'h200; d_wdata = 32'h22;
    m_ready = 1; c_req = 1; d_req = 1;
    for (int i = 0; i < 8; i++) begin
      step();
      #1;
      chk("t2_owner_seq", 64'(owner_o), 64'(tie_own[i]));
    end
    c_req = 0; d_req = 0; c_last = 0; d_last = 0;

    // ---------------- DMA 6 reads against the outstanding limit ----------------
    for (int k = 0; k < 6; k++) begin
      push_beat(2'b10, 1'b0, 32'h3000 + 32'(4 * k), 32'h0);
      push_rsp(2'b10, 32'hD000 + 32'(k));
    end
    d_we = 0; d_wdata = '0; m_ready = 1;
    b = 0; dr_cnt = 0; cr_cnt = 0;
    for (int cyc = 0; cyc <= 16; cyc++) begin
      d_req = (b < 6);
      d_last = (b == 5);
      d_addr = 32'h3000 + 32'(4 * b);
      m_rvalid = (cyc >= 10) && (cyc <= 15);
      m_rdata = 32'hD000 + 32'(cyc - 10);
      #1;
      if (d_rvalid_o) dr_cnt++;
      if (c_rvalid_o) cr_cnt++;
      if (cyc >= 5 && cyc <= 9) chk("t3_stall_no_valid", 64'(m_valid_o), 64'h0);
      if (cyc == 10) chk("t3_accepts_before_rsp", 64'(b), 64'd4);
      if (cyc >= 13 && cyc <= 15) begin
        chk("t3_drain_owner", 64'(owner_o), 64'h2);
        chk("t3_drain_no_valid", 64'(m_valid_o), 64'h0);
      end
      if (cyc == 16) chk("t3_idle_after_drain", 64'(owner_o), 64'h0);
      acc = d_ready_o;
      step();
      if (acc) b++;
    end
    m_rvalid = 0; d_req = 0; d_last = 0;
    chk("t3_d_rvalid_count", 64'(dr_cnt), 64'd6);
    chk("t3_c_rvalid_count", 64'(cr_cnt), 64'd0);

    // ---------------- backpressure on a 3-beat cache write ----------------
    bp_addr = '{32'h0, 32'h4000, 32'h4004, 32'h4004, 32'h4008, 32'h4008, 32'h0};
    for (int k = 0; k < 3; k++) push_beat(2'b01, 1'b1, 32'h4000 + 32'(4 * k), 32'hB0 + 32'(k));
    c_we = 1; b = 0;
    for (int cyc = 0; cyc <= 6; cyc++) begin
      c_req = (b < 3);
      c_last = (b == 2);
      c_addr = 32'h4000 + 32'(4 * b);
      c_wdata = 32'hB0 + 32'(b);
      m_ready = (cyc >= 1) && (cyc % 2 == 1);
      #1;
      if (cyc >= 1 && cyc <= 5) begin
        chk("t4_ready_follows_mem", 64'(c_ready_o), 64'(m_ready));
        chk("t4_addr", 64'(m_addr_o), 64'(bp_addr[cyc]));
        chk("t4_valid", 64'(m_valid_o), 64'h1);
      end
      if (cyc == 6) chk("t4_idle_after", 64'(owner_o), 64'h0);
      acc = c_ready_o;
      step();
      if (acc) b++;
    end
    c_req = 0; c_last = 0; m_ready = 1;

    // ---------------- stray response in IDLE ----------------
    m_rvalid = 1; m_rdata = 32'hEE;
    #1;
    chk("t5_no_fwd_c", 64'(c_rvalid_o), 64'h0);
    chk("t5_no_fwd_d", 64'(d_rvalid_o), 64'h0);
    chk("t5_err_before", 64'(err_o), 64'h0);
    step();
    m_rvalid = 0;
    #1;
    chk("t5_err_set", 64'(err_o), 64'h1);
    // a single read must still issue, proving the count stayed at 0
    push_beat(2'b01, 1'b0, 32'h5000, 32'h0);
    c_req = 1; c_we = 0; c_last = 1; c_addr = 32'h5000; c_wdata = '0;
    step();
    #1;
    chk("t5_read_ready", 64'(c_ready_o), 64'h1);
    step();
    c_req = 0; c_last = 0;
    #1;
    chk("t5_drain_owner", 64'(owner_o), 64'h1);
    push_rsp(2'b01, 32'h55);
    m_rvalid = 1; m_rdata = 32'h55;
    #1;
    chk("t5_rsp_fwd", 64'(c_rvalid_o), 64'h1);
    step();
    m_rvalid = 0;
    #1;
    chk("t5_idle_after", 64'(owner_o), 64'h0);
    chk("t5_err_sticky", 64'(err_o), 64'h1);

    // ---------------- reset during DRAIN_C with 2 outstanding ----------------
    push_beat(2'b01, 1'b0, 32'h6000, 32'h0);
    push_beat(2'b01, 1'b0, 32'h6004, 32'h0);
    c_req = 1; c_we = 0; c_last = 0; c_addr = 32'h6000;
    step();
    #1;
    chk("t6_beat0_ready", 64'(c_ready_o), 64'h1);
    step();
    c_addr = 32'h6004; c_last = 1;
    #1;
    chk("t6_beat1_ready", 64'(c_ready_o), 64'h1);
    step();
    c_req = 0; c_last = 0;
    #1;
    chk("t6_in_drain", 64'(owner_o), 64'h1);
    rst_n = 1'b0;
    m_rvalid = 1; m_rdata = 32'h77;
    c_we = 1; c_last = 1; c_addr = 32'h700; c_wdata = 32'h71; c_req = 1;
    d_we = 1; d_last = 1; d_addr = 32'h800; d_wdata = 32'h82; d_req = 1;
    #1;
    chk("t6_rst_owner", 64'(owner_o), 64'h0);
    chk("t6_rst_gnt", 64'({c_gnt_o, d_gnt_o}), 64'h0);
    chk("t6_rst_ready", 64'({c_ready_o, d_ready_o}), 64'h0);
    chk("t6_rst_rvalid", 64'({c_rvalid_o, d_rvalid_o}), 64'h0);
    chk("t6_rst_m_valid", 64'(m_valid_o), 64'h0);
    chk("t6_rst_m_bus", 64'({m_we_o, m_addr_o, m_wdata_o}), 64'h0);
    chk("t6_rst_err", 64'(err_o), 64'h0);
    step();
    chk("t6_rst_hold_owner", 64'(owner_o), 64'h0);
    chk("t6_rst_hold_rvalid", 64'({c_rvalid_o, d_rvalid_o}), 64'h0);
    m_rvalid = 0;
    push_beat(2'b01, 1'b1, 32'h700, 32'h71);
    push_beat(2'b10, 1'b1, 32'h800, 32'h82);
    #1;
    rst_n = 1'b1;
    step();
    #1;
    chk("t6_tie_cache_first", 64'(owner_o), 64'h1);
    step();
    #1;
    chk("t6_idle_no_drain", 64'(owner_o), 64'h0);
    step();
    #1;
    chk("t6_then_dma", 64'(owner_o), 64'h2);
    step();
    c_req = 0; d_req = 0; c_last = 0; d_last = 0;
    #1;
    chk("t6_final_idle", 64'(owner_o), 64'h0);
    step();
    step();

    chk("beats_drained", 64'(exp_beats.size()), 64'd0);
    chk("rsps_drained", 64'(exp_rsps.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
